// File: rtl/key_event_queue.sv
// Serializes one-cycle key press pulses into a FIFO of key codes, oldest first.
// Optional macro KEY_RELEASE_EVENT_EN adds release events queued behind pending presses.
module key_event_queue #(
  parameter int N_KEYS = 16,
  parameter int CODE_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_KEYS-1:0]        press_i,
`ifdef KEY_RELEASE_EVENT_EN
  input  logic [N_KEYS-1:0]        released_i,
`endif
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [CODE_W-1:0]        ev_code,
  output logic                     ev_release,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef KEY_RELEASE_EVENT_EN
  localparam int REQ_W   = 2 * N_KEYS;
  localparam int ENTRY_W = CODE_W + 1;
`else
  localparam int REQ_W   = N_KEYS;
  localparam int ENTRY_W = CODE_W;
`endif

  logic [N_KEYS-1:0]  pend_p_r;
`ifdef KEY_RELEASE_EVENT_EN
  logic [N_KEYS-1:0]  pend_r_r;
  logic [N_KEYS-1:0]  grant_r_s;
`endif
  logic [N_KEYS-1:0]  grant_p_s;
  logic [REQ_W-1:0]   req_s;
  logic [REQ_W-1:0]   grant_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               ovf_r;
  logic               valid_s;
  logic               full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               push_s;
  logic               ovf_set_s;

  // One-hot grant to entry; release bit sits above the code when enabled.
  function automatic logic [ENTRY_W-1:0] encode_grant(input logic [REQ_W-1:0] g);
    logic [ENTRY_W-1:0] e;
    e = {ENTRY_W{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      e = e | (g[i] ? ENTRY_W'(i) : {ENTRY_W{1'b0}});
`ifdef KEY_RELEASE_EVENT_EN
      e = e | (g[N_KEYS+i] ? (ENTRY_W'(i) | (ENTRY_W'(1) << CODE_W)) : {ENTRY_W{1'b0}});
`endif
    end
    return e;
  endfunction

  // Request arbitration, handshake decode and overflow detection.
  always_comb begin
`ifdef KEY_RELEASE_EVENT_EN
    req_s = {pend_r_r, pend_p_r};
`else
    req_s = pend_p_r;
`endif
    valid_s   = (count_r != {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    pop_s     = valid_s & ev_ready;
    push_ok_s = !full_s || pop_s;
    // Lowest set bit wins, so presses always precede releases.
    if (push_ok_s) begin
      grant_s = req_s & (~req_s + REQ_W'(1));
    end else begin
      grant_s = {REQ_W{1'b0}};
    end
    push_s    = |grant_s;
    entry_s   = encode_grant(grant_s);
    grant_p_s = grant_s[N_KEYS-1:0];
`ifdef KEY_RELEASE_EVENT_EN
    grant_r_s = grant_s[REQ_W-1:N_KEYS];
    ovf_set_s = |(press_i & pend_p_r & ~grant_p_s) | |(released_i & pend_r_r & ~grant_r_s);
`else
    ovf_set_s = |(press_i & pend_p_r & ~grant_p_s);
`endif
  end

  // Pending registers: clear granted bits, merge new pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p_r <= {N_KEYS{1'b0}};
`ifdef KEY_RELEASE_EVENT_EN
      pend_r_r <= {N_KEYS{1'b0}};
`endif
    end else begin
      pend_p_r <= (pend_p_r & ~grant_p_s) | press_i;
`ifdef KEY_RELEASE_EVENT_EN
      pend_r_r <= (pend_r_r & ~grant_r_s) | released_i;
`endif
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Head entry is read straight from storage registers.
  always_comb begin
    head_s   = mem_r[rd_ptr_r];
    ev_valid = valid_s;
    ev_code  = head_s[CODE_W-1:0];
`ifdef KEY_RELEASE_EVENT_EN
    ev_release = head_s[ENTRY_W-1];
`else
    ev_release = 1'b0;
`endif
    count = count_r;
    ovf   = ovf_r;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (DEPTH 8, 16 keys).
module tb_key_event_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] press_i;
  logic [15:0] released_i;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_release;
  logic [3:0]  count;
  logic        ovf;
  logic        ovf_clr;
  int          passed;
  int          total;

  key_event_queue #(.N_KEYS(16), .CODE_W(4), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .press_i    (press_i),
`ifdef KEY_RELEASE_EVENT_EN
    .released_i (released_i),
`endif
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_release (ev_release),
    .count      (count),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    press_i    = 16'h0000;
    released_i = 16'h0000;
    ev_ready   = 1'b0;
    ovf_clr    = 1'b0;
    #2;
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_code", 32'(ev_code), 32'd0);
    check("rst_release", 32'(ev_release), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Single press of key 5
    press_i = 16'h0020;
    tick();
    press_i = 16'h0000;
    check("single_lat1", 32'(ev_valid), 32'd0);
    tick();
    check("single_valid", 32'(ev_valid), 32'd1);
    check("single_code", 32'(ev_code), 32'd5);
    check("single_count", 32'(count), 32'd1);
    tick();
    check("single_hold_code", 32'(ev_code), 32'd5);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("single_pop_valid", 32'(ev_valid), 32'd0);
    check("single_pop_count", 32'(count), 32'd0);

    // Simultaneous presses 0, 8, 15 with consumer always ready
    press_i  = 16'h8101;
    ev_ready = 1'b1;
    tick();
    press_i = 16'h0000;
    tick();
    check("simul_code0", 32'(ev_code), 32'd0);
    check("simul_valid0", 32'(ev_valid), 32'd1);
    tick();
    check("simul_code8", 32'(ev_code), 32'd8);
    tick();
    check("simul_code15", 32'(ev_code), 32'd15);
    tick();
    check("simul_empty", 32'(ev_valid), 32'd0);
    check("simul_ovf", 32'(ovf), 32'd0);
    ev_ready = 1'b0;

    // Ten keys into an 8-deep FIFO: two wait in the pending register
    for (int i = 0; i < 10; i++) begin
      press_i = 16'(1) << i;
      tick();
    end
    press_i = 16'h0000;
    check("full_count", 32'(count), 32'd8);
    tick();
    tick();
    check("full_count_hold", 32'(count), 32'd8);
    check("full_head", 32'(ev_code), 32'd0);
    ev_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("full_drain_code", 32'(ev_code), 32'(i));
      tick();
    end
    ev_ready = 1'b0;
    check("full_drained", 32'(ev_valid), 32'd0);
    check("full_ovf", 32'(ovf), 32'd0);

    // Fill with keys 8..15, then duplicate key 3 while stuck pending
    for (int i = 8; i < 16; i++) begin
      press_i = 16'(1) << i;
      tick();
    end
    press_i = 16'h0000;
    tick();
    check("ovf_fill_count", 32'(count), 32'd8);
    press_i = 16'h0008;
    tick();
    press_i = 16'h0000;
    check("ovf_first_press", 32'(ovf), 32'd0);
    repeat (4) tick();
    press_i = 16'h0008;
    tick();
    press_i = 16'h0000;
    check("ovf_set", 32'(ovf), 32'd1);
    ev_ready = 1'b1;
    for (int i = 8; i < 16; i++) begin
      check("ovf_drain_code", 32'(ev_code), 32'(i));
      tick();
    end
    check("ovf_single_3", 32'(ev_code), 32'd3);
    tick();
    check("ovf_drained", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;
    check("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Duplicate of a non-granted pending bit coincides with ovf_clr
    press_i = 16'h0003;
    tick();
    press_i = 16'h0002;
    ovf_clr = 1'b1;
    tick();
    press_i = 16'h0000;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf), 32'd1);
    tick();
    check("ovf_merge_count", 32'(count), 32'd2);
    ev_ready = 1'b1;
    tick();
    tick();
    ev_ready = 1'b0;
    check("ovf_merge_drained", 32'(count), 32'd0);

    // Asynchronous reset with three queued entries and key 3 still pending
    press_i = 16'h000F;
    tick();
    press_i = 16'h0000;
    repeat (3) tick();
    check("mid_count", 32'(count), 32'd3);
    check("mid_ovf", 32'(ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ev_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_code", 32'(ev_code), 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("arst_pending_cleared", 32'(ev_valid), 32'd0);

`ifdef KEY_RELEASE_EVENT_EN
    // Press of key 2 and release of key 1 in the same cycle
    press_i    = 16'h0004;
    released_i = 16'h0002;
    tick();
    press_i    = 16'h0000;
    released_i = 16'h0000;
    tick();
    tick();
    check("rel_count", 32'(count), 32'd2);
    check("rel_code0", 32'(ev_code), 32'd2);
    check("rel_flag0", 32'(ev_release), 32'd0);
    ev_ready = 1'b1;
    tick();
    check("rel_code1", 32'(ev_code), 32'd1);
    check("rel_flag1", 32'(ev_release), 32'd1);
    tick();
    ev_ready = 1'b0;
    check("rel_drained", 32'(ev_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
Downstream consumer of the per-button debouncer instances in the calculator front end. Collects the one-cycle pressed pulses from up to N_KEYS debounced buttons and encodes each pulse into a key code. Buffers the codes in a small FIFO, oldest first, so the calculator control FSM can pop them with a valid/ready handshake. Simultaneous presses are serialized and none are lost unless the pending storage overflows.

Parameters:
N_KEYS, 16, number of debounced button inputs; range 2..(2**CODE_W).
CODE_W, 4, width of the key code; code = index of the button's bit in press_i.
DEPTH, 8, FIFO entries; must be a power of two, at least 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
press_i  input  N_KEYS  one-cycle pressed pulses, one bit per debouncer instance.
ev_valid  output  1  FIFO non-empty; head event presented.
ev_ready  input  1  consumer accepts the head event.
ev_code  output  CODE_W  key code of the head event.
ev_release  output  1  head event is a release; tied 0 unless KEY_RELEASE_EVENT_EN.
count  output  $clog2(DEPTH)+1  number of stored FIFO entries.
ovf  output  1  sticky overflow flag.
ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are cleared immediately, regardless of any operation in progress:
  - pending register P;
  - FIFO read and write pointers;
  - count = 0, ev_valid = 0, ev_code = 0, ev_release = 0, ovf = 0.
- Pending register P[N_KEYS-1:0]: next P = (P & ~grant) | press_i.
- Grant:
  - Combinational one-hot lowest set bit of P, qualified by push_ok = !full || pop.
  - When push_ok = 0, grant = 0 and P holds.
- Push: when grant != 0, the FIFO writes the encoded index of the grant bit at the write pointer and the write pointer increments.
- Pop: pop = ev_valid & ev_ready. The read pointer increments; ev_code and ev_release immediately show the next entry.
- Pointers wrap modulo DEPTH. Full/empty are derived from count; count is updated by +1 on push, -1 on pop, unchanged when both occur.
- Latency: a press_i pulse sampled at edge k sets P after edge k. It is pushed at edge k+1 (if lowest and push_ok). ev_valid rises after edge k+1, so minimum latency is 2 cycles.
- Simultaneous pulses on several bits are drained one per cycle, lowest index first.
- Full FIFO with pop in the same cycle: the push is allowed and count stays at DEPTH.
- Full FIFO without pop: events wait in P; nothing is dropped.
- Overflow: a press_i bit arriving while the same bit of P is already set (and not granted that cycle) is merged, and ovf is set.
- ovf clears on ovf_clr. If a set condition and ovf_clr occur in the same cycle, set wins.
- ev_code and ev_release are registered FIFO contents and stay stable while ev_valid = 1 and ev_ready = 0.
- Queue ordering is FIFO order. Only keys that are pending at the same time are ordered by index.

Optional Feature:
KEY_RELEASE_EVENT_EN:
- Defined:
  - Adds port released_i (input, N_KEYS) and a second pending register R with the same update rule.
  - The request vector is {R, P}; the lowest set bit wins, so all pending presses go before any pending release.
  - Each FIFO entry is CODE_W+1 bits; ev_release = 1 for release events.
  - A duplicate pulse on a bit of R also sets ovf.
- Undefined: released_i does not exist, R is not built, FIFO entries are CODE_W bits and ev_release is constant 0.

Test Plan:
- Reset mid-operation: 3 entries queued, pull rst_n low between edges → ev_valid, count and ovf drop to 0 immediately, without waiting for a clock edge.
- Single press: press_i = 0x0020 for 1 cycle at edge k, ev_ready = 0 → ev_valid = 1 after edge k+1, ev_code = 5, count = 1. Assert ev_ready for 1 cycle → ev_valid = 0, count = 0.
- Simultaneous presses: press_i = 0x8101 for 1 cycle, ev_ready = 1 → codes 0, 8, 15 appear on consecutive cycles; ovf = 0.
- Full and wait: DEPTH = 8, ev_ready = 0, pulse keys 0..9 one per cycle:
  - count saturates at 8; keys 8 and 9 wait in P;
  - then ev_ready = 1 → all ten codes 0..9 are popped in order; ovf = 0.
- Overflow: with the FIFO full, pulse key 3 twice, 5 cycles apart → ovf = 1 and only one code 3 is queued. ovf_clr pulse → ovf = 0. ovf_clr in the same cycle as a new duplicate → ovf stays 1.
- KEY_RELEASE_EVENT_EN: press_i[2] and released_i[1] pulse in the same cycle → events (2, release = 0) then (1, release = 1).
